// File: rtl/prng_dist_pkg.sv
// Shared defaults and width helpers for the PRNG readout distributor.
// Word/slice geometry and small constant functions used by the top and the arbiter.
package prng_dist_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_OUT_W  = 32;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_NUM_CH = 2;

  localparam int SLICES      = DEF_DATA_W / DEF_OUT_W;
  localparam int SLICE_IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prng_rr_arbiter.sv
// Round-robin arbiter: first requester above the last-granted channel wins, wrapping.
// The last-grant pointer only moves when a grant is actually issued.
module prng_rr_arbiter
  import prng_dist_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt
);

  localparam int PTR_W = idx_w(NUM_CH);

  logic [PTR_W-1:0] r_last;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    gnt     = '0;
    w_win   = r_last;
    w_cand  = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = PTR_W'((int'(r_last) + k) % NUM_CH);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
    if (en && w_found) begin
      gnt[w_win] = 1'b1;
    end
  end

  // Pointer starts at the top channel so channel 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= PTR_W'(NUM_CH - 1);
    end else if (en && w_found) begin
      r_last <= w_win;
    end
  end

endmodule

// File: rtl/prng_readout_distributor.sv
// Pre-fetches PRNG words into a small FIFO and hands OUT_W-bit slices, LSB first,
// to one of NUM_CH consumers per cycle under round-robin arbitration.
module prng_readout_distributor
  import prng_dist_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                         rng_clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            rng_readout,
  input  logic                         rng_readout_valid,
  input  logic                         flush,
  output logic                         prng_gen_req,
  input  logic [NUM_CH-1:0]            ch_req,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NUM_CH*OUT_W-1:0]      ch_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [31:0]                  words_served,
  output logic                         starve_1p,
  output logic                         overflow_err
);

  localparam int N_SLICES = DATA_W / OUT_W;
  localparam int SIDX_W   = idx_w(N_SLICES);
  localparam int AW       = idx_w(DEPTH);
  localparam int LVL_W    = $clog2(DEPTH + 1);

  if (DATA_W % OUT_W != 0) begin : g_bad_slice
    $error("DATA_W must be a multiple of OUT_W");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_ch
    $error("NUM_CH must be between 1 and 8");
  end

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [LVL_W-1:0]        r_level;
  logic [SIDX_W-1:0]       r_slice;
  logic                    r_pending;
  logic                    r_drop_next;
  logic                    r_gen_req;
  logic                    r_starve;
  logic                    r_overflow;
  logic [31:0]             r_served;
  logic [NUM_CH-1:0]       r_ack_p1;
  logic [NUM_CH*OUT_W-1:0] r_data_p1;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_fetch;
  logic                    w_take;
  logic                    w_push;
  logic                    w_grant_en;
  logic [NUM_CH-1:0]       w_gnt;
  logic                    w_grant;
  logic                    w_last_slice;
  logic                    w_pop;
  logic [DATA_W-1:0]       w_head;
  logic [OUT_W-1:0]        w_slice;

  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == LVL_W'(DEPTH));
  assign w_fetch      = !r_pending && (r_level < LVL_W'(DEPTH)) && !flush;
  assign w_take       = rng_readout_valid && !flush;
  assign w_push       = w_take && !r_drop_next && !w_full;
  assign w_grant_en   = !w_empty && !flush && (|ch_req);
  assign w_grant      = |w_gnt;
  assign w_last_slice = (r_slice == SIDX_W'(N_SLICES - 1));
  assign w_pop        = w_grant && w_last_slice;
  assign w_head       = r_mem[r_rd_ptr];

  always_comb begin
    w_slice = '0;
    for (int k = 0; k < N_SLICES; k++) begin
      if (r_slice == SIDX_W'(k)) begin
        w_slice = w_head[k*OUT_W +: OUT_W];
      end
    end
  end

  prng_rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk   (rng_clk),
    .rst_n (rst_n),
    .req   (ch_req),
    .en    (w_grant_en),
    .gnt   (w_gnt)
  );

  // FIFO storage is data only; occupancy is tracked by the pointers and level.
  always_ff @(posedge rng_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= rng_readout;
    end
  end

  // Stage boundary: grant decision in t, ack/data registered and visible in t+1.
  always_ff @(posedge rng_clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_slice     <= '0;
      r_pending   <= 1'b0;
      r_drop_next <= 1'b0;
      r_gen_req   <= 1'b0;
      r_starve    <= 1'b0;
      r_overflow  <= 1'b0;
      r_served    <= '0;
      r_ack_p1    <= '0;
      r_data_p1   <= '0;
    end else begin
      r_gen_req <= w_fetch;
      r_ack_p1  <= w_gnt;
      r_starve  <= w_pop && (r_level == LVL_W'(1)) && !w_push && (|ch_req);

      if (w_grant) begin
        r_served <= sat_inc(r_served);
        for (int c = 0; c < NUM_CH; c++) begin
          if (w_gnt[c]) begin
            r_data_p1[c*OUT_W +: OUT_W] <= w_slice;
          end
        end
      end

      if (w_take && !r_drop_next && w_full) begin
        r_overflow <= 1'b1;
      end

      if (flush) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_level   <= '0;
        r_slice   <= '0;
        r_pending <= 1'b0;
        // A word arriving during the flush answers the oldest outstanding request.
        r_drop_next <= (r_pending && !(rng_readout_valid && !r_drop_next)) ||
                       (r_drop_next && !rng_readout_valid);
      end else begin
        if (w_push) begin
          r_wr_ptr <= next_ptr(r_wr_ptr);
        end
        if (w_pop) begin
          r_rd_ptr <= next_ptr(r_rd_ptr);
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
        if (w_grant) begin
          r_slice <= w_last_slice ? '0 : r_slice + 1'b1;
        end
        // The discarded late word belongs to the pre-flush request, not the current one.
        if (w_fetch) begin
          r_pending <= 1'b1;
        end else if (rng_readout_valid && !r_drop_next) begin
          r_pending <= 1'b0;
        end
        if (rng_readout_valid && r_drop_next) begin
          r_drop_next <= 1'b0;
        end
      end
    end
  end

  assign prng_gen_req = r_gen_req;
  assign ch_ack       = r_ack_p1;
  assign ch_data      = r_data_p1;
  assign fifo_level   = r_level;
  assign words_served = r_served;
  assign starve_1p    = r_starve;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_prng_readout_distributor.sv
// Self-checking bench: core model answers fetch requests, scoreboard checks every
// delivered slice in order, table drives the slicing sequence, hand sequences cover corners.
module tb_prng_readout_distributor;

  localparam int DATA_W = 128;
  localparam int OUT_W  = 32;
  localparam int DEPTH  = 4;
  localparam int NUM_CH = 2;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic                       rng_clk = 1'b0;
  logic                       rst_n;
  logic [DATA_W-1:0]          rng_readout;
  logic                       rng_readout_valid;
  logic                       flush;
  logic                       prng_gen_req;
  logic [NUM_CH-1:0]          ch_req;
  logic [NUM_CH-1:0]          ch_ack;
  logic [NUM_CH*OUT_W-1:0]    ch_data;
  logic [LVL_W-1:0]           fifo_level;
  logic [31:0]                words_served;
  logic                       starve_1p;
  logic                       overflow_err;

  always #5 rng_clk = ~rng_clk;

  prng_readout_distributor #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .rng_clk           (rng_clk),
    .rst_n             (rst_n),
    .rng_readout       (rng_readout),
    .rng_readout_valid (rng_readout_valid),
    .flush             (flush),
    .prng_gen_req      (prng_gen_req),
    .ch_req            (ch_req),
    .ch_ack            (ch_ack),
    .ch_data           (ch_data),
    .fifo_level        (fifo_level),
    .words_served      (words_served),
    .starve_1p         (starve_1p),
    .overflow_err      (overflow_err)
  );

  typedef struct {
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] ack;
    logic [31:0]       lane0;
    logic [31:0]       ws;
    logic [LVL_W-1:0]  lvl;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          core_lat = 2;
  bit          core_hold = 1'b0;
  bit          next_drop = 1'b0;
  int          drop_cyc = -100;
  int          word_idx = 0;
  int          last_ch = NUM_CH - 1;
  int          ack_cnt = 0;
  int          starve_cnt = 0;
  int          req_cnt = 0;
  int          resp_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] make_word(input int idx);
    if (idx == 0) return 128'h33333333_22222222_11111111_00000000;
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One clock: sample at the falling edge, check any grant, then run the core model.
  task automatic tick();
    logic [DATA_W-1:0] w;
    logic [31:0]       lane;
    int                ch;
    @(negedge rng_clk);
    cyc++;
    if (prng_gen_req) req_cnt++;
    if (starve_1p) starve_cnt++;
    if (ch_ack != '0) begin
      ack_cnt++;
      chk("ack_onehot", 64'($countones(ch_ack)), 64'd1);
      ch = 0;
      for (int c = 0; c < NUM_CH; c++) if (ch_ack[c]) ch = c;
      last_ch = ch;
      lane = 32'(ch_data >> (ch * OUT_W));
      chk("sb_slice_available", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("sb_slice", lane, exp_q.pop_front());
    end
    rng_readout_valid = 1'b0;
    if (!core_hold && resp_q.size() > 0 && resp_q[0] <= cyc) begin
      void'(resp_q.pop_front());
      w = make_word(word_idx);
      word_idx++;
      rng_readout       = w;
      rng_readout_valid = 1'b1;
      if (next_drop) begin
        next_drop = 1'b0;
        drop_cyc  = cyc;
      end else begin
        for (int k = 0; k < DATA_W / OUT_W; k++) exp_q.push_back(32'(w >> (k * OUT_W)));
      end
    end
    if (prng_gen_req) resp_q.push_back(cyc + core_lat);
  endtask

  task automatic wait_level(input int tgt, input int bound);
    int i;
    i = 0;
    while (int'(fifo_level) != tgt && i < bound) begin
      tick();
      i++;
    end
    chk("wait_level", 64'(fifo_level), 64'(tgt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[5];
    int          exp_ch;
    int          fetch_cnt;
    int          seen;
    logic [31:0] lane0_prev;

    tbl[0] = '{req: 2'b01, ack: 2'b01, lane0: 32'h00000000, ws: 32'd1, lvl: 3'd4};
    tbl[1] = '{req: 2'b01, ack: 2'b01, lane0: 32'h11111111, ws: 32'd2, lvl: 3'd4};
    tbl[2] = '{req: 2'b01, ack: 2'b01, lane0: 32'h22222222, ws: 32'd3, lvl: 3'd4};
    tbl[3] = '{req: 2'b01, ack: 2'b01, lane0: 32'h33333333, ws: 32'd4, lvl: 3'd3};
    tbl[4] = '{req: 2'b00, ack: 2'b00, lane0: 32'h33333333, ws: 32'd4, lvl: 3'd3};

    rst_n = 1'b0; flush = 1'b0; ch_req = '0;
    rng_readout = '0; rng_readout_valid = 1'b0;
    repeat (3) tick();
    chk("rst_gen_req", 64'(prng_gen_req), 64'd0);
    chk("rst_ack", 64'(ch_ack), 64'd0);
    chk("rst_data", 64'(ch_data), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_served", 64'(words_served), 64'd0);
    chk("rst_overflow", 64'(overflow_err), 64'd0);
    chk("rst_starve", 64'(starve_1p), 64'd0);

    // Fill with no consumers: exactly DEPTH fetches, then silence.
    rst_n = 1'b1;
    req_cnt = 0;
    wait_level(4, 60);
    repeat (10) tick();
    chk("fill_req_count", 64'(req_cnt), 64'd4);
    chk("fill_level", 64'(fifo_level), 64'd4);

    // Slice order for the first word on channel 0.
    for (int i = 0; i < 5; i++) begin
      ch_req = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d_ack", i), 64'(ch_ack), 64'(tbl[i].ack));
      chk($sformatf("tbl%0d_lane0", i), 64'(ch_data[OUT_W-1:0]), 64'(tbl[i].lane0));
      chk($sformatf("tbl%0d_served", i), 64'(words_served), 64'(tbl[i].ws));
      chk($sformatf("tbl%0d_level", i), 64'(fifo_level), 64'(tbl[i].lvl));
    end

    // Both channels requesting: strict alternation, other lane holds.
    wait_level(4, 40);
    ch_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      exp_ch     = (last_ch + 1) % NUM_CH;
      lane0_prev = ch_data[OUT_W-1:0];
      tick();
      chk($sformatf("rr_grant%0d", i), 64'(ch_ack), 64'(1 << exp_ch));
      if (exp_ch == 1) chk($sformatf("rr_lane0_hold%0d", i), 64'(ch_data[OUT_W-1:0]), 64'(lane0_prev));
    end
    ch_req = '0;
    tick();
    chk("rr_release", 64'(ch_ack), 64'd0);

    // Flush with a request outstanding: the late word must vanish.
    wait_level(4, 40);
    core_lat = 6;
    ch_req = 2'b01;
    repeat (4) tick();
    ch_req = '0;
    seen = 0;
    for (int i = 0; i < 30 && seen == 0; i++) begin
      tick();
      if (prng_gen_req) seen = 1;
    end
    chk("flush_prereq_seen", 64'(seen), 64'd1);
    flush = 1'b1;
    exp_q.delete();
    next_drop = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", 64'(fifo_level), 64'd0);
    chk("flush_no_ack", 64'(ch_ack), 64'd0);
    fetch_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 4 && prng_gen_req) fetch_cnt++;
      if (cyc == drop_cyc + 1) chk("late_word_dropped_level", 64'(fifo_level), 64'd0);
      if (cyc == drop_cyc + 3) chk("post_flush_push_level", 64'(fifo_level), 64'd1);
    end
    chk("flush_refetch", 64'(fetch_cnt), 64'd1);
    chk("late_word_delivered", 64'(next_drop), 64'd0);
    core_lat = 2;

    // Unsolicited word into a full FIFO: sticky overflow.
    wait_level(4, 80);
    repeat (3) tick();
    chk("ovf_before", 64'(overflow_err), 64'd0);
    rng_readout = {4{32'hBADBAD00}};
    rng_readout_valid = 1'b1;
    tick();
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    repeat (3) tick();
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // Drain with the core stalled: one starve pulse, no grants while empty.
    core_hold = 1'b1;
    ch_req = 2'b01;
    ack_cnt = 0;
    starve_cnt = 0;
    repeat (24) tick();
    chk("drain_ack_count", 64'(ack_cnt), 64'd16);
    chk("drain_starve_count", 64'(starve_cnt), 64'd1);
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("drain_ovf_sticky", 64'(overflow_err), 64'd1);
    core_hold = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ch_ack[0]) seen = 1;
    end
    chk("resume_after_push", 64'(seen), 64'd1);

    // Reset mid-traffic clears everything including the sticky flag.
    ch_req = '0;
    rst_n = 1'b0;
    resp_q.delete();
    tick();
    tick();
    exp_q.delete();
    last_ch = NUM_CH - 1;
    chk("rst2_overflow", 64'(overflow_err), 64'd0);
    chk("rst2_level", 64'(fifo_level), 64'd0);
    chk("rst2_served", 64'(words_served), 64'd0);
    chk("rst2_data", 64'(ch_data), 64'd0);

    // Unsolicited word right after reset is accepted and served.
    rst_n = 1'b1;
    rng_readout = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    rng_readout_valid = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(rng_readout >> (k * OUT_W)));
    tick();
    chk("unsolicited_level", 64'(fifo_level), 64'd1);
    ch_req = 2'b10;
    ack_cnt = 0;
    repeat (4) tick();
    ch_req = '0;
    chk("post_rst_ack_count", 64'(ack_cnt), 64'd4);
    chk("post_rst_served", 64'(words_served), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
